// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader                                                                |
// | Framed byte-stream writer for the Aardvark instruction memory with        |
// | checksum verification; holds the CPU until a good image has been loaded.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module prog_loader #(
   parameter logic [7:0] BASE_ADDR = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       cpu_hold,
   output logic       done,
   output logic       err,
   output logic [7:0] byte_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t     r_state;
   logic [7:0] r_ptr;
   logic [7:0] r_sum;
   logic [8:0] r_rem;
   logic       r_in_ready;
   logic       r_mem_we;
   logic [7:0] r_mem_addr;
   logic [7:0] r_mem_wdata;
   logic       r_cpu_hold;
   logic       r_done;
   logic       r_err;
   logic [7:0] r_byte_count;

   logic       w_xfer;
   logic [7:0] w_check;
   logic [8:0] w_len;

   assign w_xfer  = in_valid & r_in_ready;
   assign w_check = r_sum + in_data;
   // A length byte of zero encodes a full 256-byte image.
   assign w_len   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ptr        <= BASE_ADDR;
         r_sum        <= 8'h00;
         r_rem        <= 9'd0;
         r_in_ready   <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 8'h00;
         r_mem_wdata  <= 8'h00;
         r_cpu_hold   <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_byte_count <= 8'h00;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_state      <= S_LEN;
                  r_ptr        <= BASE_ADDR;
                  r_sum        <= 8'h00;
                  r_in_ready   <= 1'b1;
                  r_cpu_hold   <= 1'b1;
                  r_done       <= 1'b0;
                  r_err        <= 1'b0;
                  r_byte_count <= 8'h00;
               end
            end
            S_LEN: begin
               if (w_xfer) begin
                  r_rem   <= w_len;
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_mem_we     <= 1'b1;
                  r_mem_addr   <= r_ptr;
                  r_mem_wdata  <= in_data;
                  r_ptr        <= r_ptr + 8'd1;
                  r_sum        <= w_check;
                  r_byte_count <= r_byte_count + 8'd1;
                  r_rem        <= r_rem - 9'd1;
                  if (r_rem == 9'd1) begin
                     r_state <= S_CSUM;
                  end
               end
            end
            S_CSUM: begin
               if (w_xfer) begin
                  r_in_ready <= 1'b0;
                  if (w_check == 8'h00) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_cpu_hold <= 1'b0;
                  end else begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign cpu_hold   = r_cpu_hold;
   assign done       = r_done;
   assign err        = r_err;
   assign byte_count = r_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prog_loader                                                             |
// | Scoreboard bench: two loaders (base 00 and FE) fed the same random frames. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       rdy0, we0, hold0, done0, err0;
   logic [7:0] addr0, wdata0, bc0;
   logic       rdy1, we1, hold1, done1, err1;
   logic [7:0] addr1, wdata1, bc1;

   int n_cmp = 0;
   int n_fail = 0;

   logic [15:0] q0[$];
   logic [15:0] q1[$];
   logic [7:0]  pl[$];
   logic [7:0]  csum;

   always #5 clk = ~clk;

   prog_loader #(.BASE_ADDR(8'h00)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
      .cpu_hold(hold0), .done(done0), .err(err0), .byte_count(bc0)
   );

   prog_loader #(.BASE_ADDR(8'hFE)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
      .cpu_hold(hold1), .done(done1), .err(err1), .byte_count(bc1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: every write strobe must match the oldest expected (addr,data).
   always @(negedge clk) begin
      if (we0) begin
         if (q0.size() == 0) begin
            chk("dut0 unexpected write", {8'h00, addr0, wdata0, 8'h00}, 32'hFFFF_FFFF);
         end else begin
            chk("dut0 write", {16'h0, addr0, wdata0}, {16'h0, q0.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (we1) begin
         if (q1.size() == 0) begin
            chk("dut1 unexpected write", {8'h00, addr1, wdata1, 8'h00}, 32'hFFFF_FFFF);
         end else begin
            chk("dut1 write", {16'h0, addr1, wdata1}, {16'h0, q1.pop_front()});
         end
      end
   end

   task automatic chk_state(input logic rdy, input logic hold, input logic dn,
                            input logic er, input logic [7:0] bc);
      chk("dut0 in_ready", {31'h0, rdy0}, {31'h0, rdy});
      chk("dut0 cpu_hold", {31'h0, hold0}, {31'h0, hold});
      chk("dut0 done", {31'h0, done0}, {31'h0, dn});
      chk("dut0 err", {31'h0, err0}, {31'h0, er});
      chk("dut0 byte_count", {24'h0, bc0}, {24'h0, bc});
      chk("dut1 in_ready", {31'h0, rdy1}, {31'h0, rdy});
      chk("dut1 cpu_hold", {31'h0, hold1}, {31'h0, hold});
      chk("dut1 done", {31'h0, done1}, {31'h0, dn});
      chk("dut1 err", {31'h0, err1}, {31'h0, er});
      chk("dut1 byte_count", {24'h0, bc1}, {24'h0, bc});
   endtask

   task automatic chk_reset();
      chk_state(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("dut0 reset mem_we", {31'h0, we0}, 32'h0);
      chk("dut0 reset mem_addr", {24'h0, addr0}, 32'h0);
      chk("dut0 reset mem_wdata", {24'h0, wdata0}, 32'h0);
      chk("dut1 reset mem_we", {31'h0, we1}, 32'h0);
      chk("dut1 reset mem_addr", {24'h0, addr1}, 32'h0);
      chk("dut1 reset mem_wdata", {24'h0, wdata1}, 32'h0);
   endtask

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic send(input logic [7:0] b, input int stall_pct, input bit pulse_start);
      int cyc;
      bit acc;
      for (int k = 0; k < 3 && $urandom_range(0, 99) < stall_pct; k++) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      if (pulse_start) start = 1'b1;
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 1000) begin
         acc = rdy0;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      in_valid = 1'b0;
      if (!acc) chk("handshake timeout", 32'h0, 32'h1);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk_state(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic push_expected(input int i);
      q0.push_back({8'(8'h00 + i), pl[i]});
      q1.push_back({8'(8'hFE + i), pl[i]});
   endtask

   task automatic do_frame(input int stall_pct, input int start_at);
      int  n;
      int  s;
      bit  good;
      logic [7:0] len;
      n = pl.size();
      s = 0;
      len = 8'(n);
      do_start();
      send(len, stall_pct, 1'b0);
      for (int i = 0; i < n; i++) begin
         push_expected(i);
         s += int'(pl[i]);
         send(pl[i], stall_pct, i == start_at);
      end
      send(csum, stall_pct, 1'b0);
      good = ((s + int'(csum)) % 256) == 0;
      chk_state(1'b0, !good, good, !good, 8'(n));
      // Bytes offered after the frame must be ignored.
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk_state(1'b0, !good, good, !good, 8'(n));
      chk("dut0 writes drained", q0.size(), 32'h0);
      chk("dut1 writes drained", q1.size(), 32'h0);
   endtask

   task automatic set_basic(input logic [7:0] c);
      pl = '{8'hE5, 8'h10, 8'h2A};
      csum = c;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation timed out at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int s;
      #1;
      chk_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_reset();

      set_basic(8'hE1);
      do_frame(0, -1);

      set_basic(8'hE0);
      do_frame(0, -1);

      set_basic(8'hE1);
      do_frame(60, -1);

      pl.delete();
      for (int i = 0; i < 256; i++) pl.push_back(8'h01);
      csum = 8'h00;
      do_frame(0, -1);

      set_basic(8'hE1);
      do_frame(0, 1);

      // Abort after two of three payload bytes.
      set_basic(8'hE1);
      do_start();
      send(8'h03, 0, 1'b0);
      push_expected(0);
      send(pl[0], 0, 1'b0);
      push_expected(1);
      send(pl[1], 0, 1'b0);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_reset();
      @(posedge clk); #1;
      chk_reset();
      chk("dut0 writes before reset", q0.size(), 32'h0);
      chk("dut1 writes before reset", q1.size(), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_frame(0, -1);

      for (int f = 0; f < 20; f++) begin
         pl.delete();
         n = $urandom_range(1, 40);
         s = 0;
         for (int i = 0; i < n; i++) begin
            pl.push_back(8'($urandom));
            s += int'(pl[i]);
         end
         csum = ($urandom_range(0, 99) < 70) ? 8'((256 - (s % 256)) % 256) : 8'($urandom);
         do_frame($urandom_range(0, 50), (f % 4 == 0) ? int'($urandom_range(0, n - 1)) : -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the 8-bit Aardvark computer: the writer side of the instruction memory that the datapath reads from. It accepts a framed program image over a valid/ready byte interface, writes each payload byte into sequential memory addresses and verifies a checksum. It holds the CPU while loading and releases it only after a good image.

## Interface
- BASE_ADDR, 8'h00, first memory address written by a load
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a new load
- in_valid  input  1  in_data holds a byte
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle; transfer when in_valid && in_ready
- mem_we  output  1  memory write strobe, one cycle per payload byte
- mem_addr  output  8  write address
- mem_wdata  output  8  write data
- cpu_hold  output  1  keep the CPU/PC frozen
- done  output  1  image loaded and checksum good; level
- err  output  1  checksum mismatch; level
- byte_count  output  8  payload bytes written in the current/last load

## Operation
- Frame: LEN byte N (8'h00 means 256), then N payload bytes, then CSUM byte. The image is good when (sum of payload + CSUM) mod 256 == 0.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start -> LEN:
  - clear done, err, byte_count and the running sum
  - set the address pointer to BASE_ADDR
  - cpu_hold = 1
- LEN: on transfer, latch the remaining count, then go to DATA. The remaining count is 9 bits so that N = 0 is loaded as 256.
- DATA: on each transfer:
  - register mem_addr = pointer, mem_wdata = in_data, mem_we = 1
  - pointer += 1, wrapping 8'hFF -> 8'h00
  - sum += in_data (mod 256)
  - byte_count += 1 (wraps to 0 after 256 bytes)
  - remaining -= 1; when remaining reaches 0, go to CSUM
- CSUM: on transfer, evaluate (sum + in_data) mod 256.
  - If 0 -> DONE: done = 1, cpu_hold = 0.
  - Otherwise -> ERR: err = 1, cpu_hold stays 1.
- start while in LEN, DATA or CSUM is ignored.
- in_ready = 1 exactly in LEN, DATA and CSUM; 0 otherwise.
- in_valid while in_ready = 0 has no effect.
- Gaps in in_valid simply stall the current state, with no timeout.
- Asynchronous reset mid-load aborts immediately:
  - state = IDLE
  - all outputs take their reset values
  - memory contents already written are left as they are

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 8'h00, mem_wdata 8'h00, cpu_hold 0, done 0, err 0, byte_count 0.
- start sampled at edge T: state = LEN, cpu_hold = 1 and in_ready = 1 from T+1.
- Write latency: a payload byte accepted at edge T appears on mem_we/mem_addr/mem_wdata during cycle T..T+1. mem_we is deasserted the next cycle unless another byte is accepted.
- Full throughput: one byte per cycle, so back-to-back writes hold mem_we continuously high.
- The CSUM byte accepted at edge T gives done or err = 1 and in_ready = 0 from T+1. cpu_hold falls at T+1 on success.
- Minimum load time (N bytes, continuous valid): N+2 accepting cycles after the start cycle.
- byte_count is updated at the same edge as its write is registered.

## Test plan
- Basic load, BASE_ADDR 0:
  - stimulus: start; stream 03, E5, 10, 2A, CSUM = 8'hE1
  - required: writes (00,E5), (01,10), (02,2A) on consecutive cycles; done = 1, cpu_hold = 0, byte_count = 3, err = 0
- Bad checksum:
  - stimulus: same frame with CSUM = 8'hE0
  - required: three writes still occur; err = 1, done = 0, cpu_hold stays 1, in_ready = 0
- Stalled stream:
  - stimulus: in_valid toggles 1, 0, 0, 1 during DATA
  - required: exactly one write per accepted byte, no duplicate writes; final memory and done identical to the basic load
- Wrap and N = 0:
  - stimulus: BASE_ADDR = 8'hFE; LEN = 00; 256 bytes of value 8'h01; CSUM = 8'h00
  - required: addresses run FE, FF, 00, ..., FD; 256 writes; byte_count = 0; done = 1
- Reset mid-load:
  - stimulus: assert rst_n low after 2 of 3 payload bytes
  - required: next cycle all outputs are at reset values and state is IDLE; a subsequent start plus a full frame loads correctly
- Start ignored:
  - stimulus: pulse start during DATA
  - required: no restart; pointer, byte_count and sum continue unchanged; the frame completes normally
